// File: rtl/dlx_mem_arbiter.sv
// dlx_mem_arbiter: shares one single-port memory between the DLX core and a host/loader port.
// The core's level-held mr/mw + busy handshake becomes a req/ack memory transaction. When both
// sides request at once, round-robin arbitration decides who goes first.
// Optional build macro: DLX_MEM_ARB_TIMEOUT_EN adds an abort after TIMEOUT cycles without
// mem_ack, returns all-ones read data and raises the sticky arb_err.
module dlx_mem_arbiter #(
  parameter int unsigned AW      = 10,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_mr,
  input  logic          core_mw,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_busy,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_gnt,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          arb_err,
  output logic [2:0]    arb_state
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StCoreAcc  = 3'd1,
    StCoreDone = 3'd2,
    StHostAcc  = 3'd3,
    StHostDone = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          last_gnt_host_q;  // 1 when the host received the most recent grant
  logic          core_req;
  logic          grant_core, grant_host;
  logic          acc_done;
  logic          timeout_hit;
  logic          mem_req_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] core_rdata_q, host_rdata_q;

  assign core_req = core_mr | core_mw;
  assign acc_done = mem_ack | timeout_hit;

`ifdef DLX_MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic            in_acc;
  logic [CntW-1:0] wait_cnt_q;
  logic            arb_err_q;

  assign in_acc      = (state_q == StCoreAcc) || (state_q == StHostAcc);
  assign timeout_hit = in_acc && !mem_ack && (wait_cnt_q == CntW'(TIMEOUT));
  assign arb_err     = arb_err_q;

  // Wait counter: cleared on every grant, counts ACC cycles spent without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      arb_err_q  <= 1'b0;
    end else begin
      if (grant_core || grant_host) begin
        wait_cnt_q <= '0;
      end else if (in_acc && !mem_ack && !timeout_hit) begin
        wait_cnt_q <= wait_cnt_q + CntW'(1);
      end
      if (timeout_hit) begin
        arb_err_q <= 1'b1;
      end
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign arb_err        = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and grant decode; grants are only issued from IDLE.
  always_comb begin
    state_d    = state_q;
    grant_core = 1'b0;
    grant_host = 1'b0;
    case (state_q)
      StIdle: begin
        if (core_req && (!host_req || last_gnt_host_q)) begin
          state_d    = StCoreAcc;
          grant_core = 1'b1;
        end else if (host_req) begin
          state_d    = StHostAcc;
          grant_host = 1'b1;
        end
      end
      StCoreAcc:  if (acc_done) state_d = StCoreDone;
      StCoreDone: state_d = StIdle;
      StHostAcc:  if (acc_done) state_d = StHostDone;
      StHostDone: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Memory-side request registers, read-data capture and round-robin history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      core_rdata_q    <= '0;
      host_rdata_q    <= '0;
      last_gnt_host_q <= 1'b1;  // core wins the first tie
    end else begin
      if (grant_core) begin
        mem_req_q       <= 1'b1;
        mem_we_q        <= core_mw;  // mr+mw together counts as a write
        mem_addr_q      <= core_addr;
        mem_wdata_q     <= core_wdata;
        last_gnt_host_q <= 1'b0;
      end else if (grant_host) begin
        mem_req_q       <= 1'b1;
        mem_we_q        <= host_we;
        mem_addr_q      <= host_addr;
        mem_wdata_q     <= host_wdata;
        last_gnt_host_q <= 1'b1;
      end else if ((state_q == StCoreAcc) && acc_done) begin
        core_rdata_q <= timeout_hit ? {DW{1'b1}} : mem_rdata;
        mem_req_q    <= 1'b0;
        mem_we_q     <= 1'b0;
      end else if ((state_q == StHostAcc) && acc_done) begin
        host_rdata_q <= timeout_hit ? {DW{1'b1}} : mem_rdata;
        mem_req_q    <= 1'b0;
        mem_we_q     <= 1'b0;
      end
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    core_busy = core_req && (state_q != StCoreDone);
    host_gnt  = (state_q == StHostDone);
    arb_state = state_q;
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rdata = core_rdata_q;
  assign host_rdata = host_rdata_q;

endmodule
